imem_arbiter: RTL and testbench
===============================

// Module: imem_arbiter
// PURPOSE
//  Shares the single combinational read port of imem between two requesters:
//  port 0 = core fetch, port 1 = debug/loader read-back.
//  Round-robin arbitration with an optional per-port lock for back-to-back reads.
//  Read data is registered: each granted read returns one cycle later.
//  Sits between the requesters and imem #(N); imem q feeds mem_q.
// PARAMETERS
//  N   32  instruction/data width (matches imem #(N))
//  AW  6   word address width (imem addr)
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  reset      in   1   asynchronous, active-low (0 = reset)
//  req0       in   1   port 0 read request
//  addr0      in   AW  port 0 word address
//  lock0      in   1   port 0 keeps ownership after this read
//  gnt0       out  1   port 0 read accepted this cycle (combinational)
//  rvalid0    out  1   rdata0 valid, one-cycle pulse
//  rdata0     out  N   port 0 read data, held until next port 0 response
//  req1/addr1/lock1/gnt1/rvalid1/rdata1   same as port 0, for port 1
//  mem_addr   out  AW  to imem addr
//  mem_q      in   N   from imem q (combinational)
// BEHAVIOUR
//  - Reset values: gnt0/1=0, rvalid0/1=0, rdata0/1=0, state=IDLE, last=1
//    (port 0 wins the first contention). gnt0/1 forced 0 while reset=0.
//  - State machine: IDLE, LOCK0, LOCK1.
//    IDLE: one request -> grant it; both -> grant port != last.
//    LOCKi: only port i can be granted; the other port's req is stalled.
//    Grant i with lock_i=1 -> LOCKi. Grant i with lock_i=0 -> IDLE.
//    In LOCKi with req_i=0 -> IDLE next cycle, no grant in that cycle.
//  - last <= granted port on every grant, including grants made in LOCK states.
//  - At most one gnt per cycle. mem_addr = addr of the granted port.
//    With no grant, mem_addr = addr0.
//  - Latency: on the edge after gnt_i=1, rdata_i <= mem_q and rvalid_i=1
//    for exactly one cycle. Throughput is 1 read/cycle per owner.
//  - Requester holds req/addr/lock stable until gnt is seen.
//    A request dropped before gnt is discarded.
//  - Address is passed unchecked. Out-of-range words return whatever imem
//    drives (0 beyond the program).
//  - Reset asserted mid-operation: the in-flight response is dropped
//    (rvalid stays 0), lock is released, and last returns to 1.
// CONFIGURATION
//  IMEM_ARB_STATS_EN defined: adds outputs
//    gcnt0 [15:0]  grants to port 0
//    gcnt1 [15:0]  grants to port 1
//    ccnt  [15:0]  cycles where a req was stalled by the other port
//  - All three counters saturate at 16'hFFFF and reset to 0.
//  IMEM_ARB_STATS_EN undefined: these ports and counters do not exist;
//  behaviour is otherwise identical.
// TESTING (imem loaded with program, word0=32'hf8000001, word1=32'hf8008002)
//  1 Reset: reset=0 with req0=req1=1 -> gnt0/1=0, rvalid=0, rdata=0.
//    Release reset -> first cycle gnt0=1.
//  2 Single read: req0=1, addr0=0 -> gnt0=1.
//    Next cycle rvalid0=1, rdata0=32'hf8000001.
//    rvalid1 stays 0 throughout.
//  3 Contention: req0=req1=1 for 4 cycles, lock=0, addr0=0, addr1=1.
//    -> grants 0,1,0,1.
//    -> rdata1=32'hf8008002 on each port-1 response.
//  4 Lock: port 1 lock1=1 for 3 reads while req0=1.
//    -> gnt1 3 consecutive cycles, gnt0=0 throughout.
//    -> After lock1=0 read, gnt0=1 next cycle.
//    Also: req1 dropped in LOCK1 -> no grant that cycle, then gnt0.
//  5 Reset mid-read: assert reset the cycle after gnt0.
//    -> rvalid0 never pulses, state IDLE, last=1.
//  6 Stats (IMEM_ARB_STATS_EN): run test 3.
//    -> gcnt0=2, gcnt1=2, ccnt=4.
//    Force gcnt0 to 16'hFFFF then grant port 0 -> stays 16'hFFFF.

Source files
------------

// File: rtl/imem_arbiter.sv
// Two-port round-robin arbiter in front of the combinational imem read port.
// Optional grant/stall counters are compiled in with IMEM_ARB_STATS_EN.
module imem_arbiter #(
  parameter int N  = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          lock0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [N-1:0]  rdata0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic          lock1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [N-1:0]  rdata1,
  output logic [AW-1:0] mem_addr,
  input  logic [N-1:0]  mem_q
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [15:0]   gcnt0,
  output logic [15:0]   gcnt1,
  output logic [15:0]   ccnt
`endif
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t         state_q;
  logic           last_q;
  logic           rvalid0_q, rvalid1_q;
  logic [N-1:0]   rdata0_q, rdata1_q;
  logic           gnt0_d, gnt1_d;

  // last_q names the port that won most recently; the other one wins a tie.
  always_comb begin
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt0_d = req0 & (~req1 | last_q);
        gnt1_d = req1 & (~req0 | ~last_q);
      end
      LOCK0:   gnt0_d = req0;
      LOCK1:   gnt1_d = req1;
      default: ;
    endcase
  end

  assign gnt0     = reset & gnt0_d;
  assign gnt1     = reset & gnt1_d;
  assign mem_addr = gnt1 ? addr1 : addr0;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;
      if (gnt0) begin
        rdata0_q <= mem_q;
        last_q   <= 1'b0;
        state_q  <= lock0 ? LOCK0 : IDLE;
      end else if (gnt1) begin
        rdata1_q <= mem_q;
        last_q   <= 1'b1;
        state_q  <= lock1 ? LOCK1 : IDLE;
      end else if (state_q != IDLE) begin
        // Owner stopped requesting: release the lock, grant nobody this cycle.
        state_q <= IDLE;
      end
    end
  end

`ifdef IMEM_ARB_STATS_EN
  logic [15:0] gcnt0_q, gcnt1_q, ccnt_q;
  logic        stall;

  assign stall = (req0 & ~gnt0) | (req1 & ~gnt1);
  assign gcnt0 = gcnt0_q;
  assign gcnt1 = gcnt1_q;
  assign ccnt  = ccnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      ccnt_q  <= '0;
    end else begin
      if (gnt0 && gcnt0_q != 16'hFFFF) gcnt0_q <= gcnt0_q + 16'd1;
      if (gnt1 && gcnt1_q != 16'hFFFF) gcnt1_q <= gcnt1_q + 16'd1;
      if (stall && ccnt_q != 16'hFFFF) ccnt_q <= ccnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: per-cycle vector table plus hand-written
// reset/lock corner sequences; stats checks compile in with IMEM_ARB_STATS_EN.
module tb_imem_arbiter;

  localparam int N  = 32;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, lock0, req1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [N-1:0]  rdata0, rdata1, mem_q;
  logic [AW-1:0] mem_addr;
`ifdef IMEM_ARB_STATS_EN
  logic [15:0]   gcnt0, gcnt1, ccnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.N(N), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .lock0(lock0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .lock1(lock1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_q(mem_q)
`ifdef IMEM_ARB_STATS_EN
    , .gcnt0(gcnt0), .gcnt1(gcnt1), .ccnt(ccnt)
`endif
  );

  // Small program image; everything past word 3 reads as zero.
  always_comb begin
    case (mem_addr)
      6'd0:    mem_q = 32'hf8000001;
      6'd1:    mem_q = 32'hf8008002;
      6'd2:    mem_q = 32'h12345678;
      6'd3:    mem_q = 32'hcafef00d;
      default: mem_q = 32'h0;
    endcase
  end

  localparam logic [31:0] W0 = 32'hf8000001;
  localparam logic [31:0] W1 = 32'hf8008002;
  localparam logic [31:0] W2 = 32'h12345678;
  localparam logic [31:0] W3 = 32'hcafef00d;

  typedef struct {
    string         name;
    logic          r0;
    logic [AW-1:0] a0;
    logic          l0;
    logic          r1;
    logic [AW-1:0] a1;
    logic          l1;
    logic          e_g0, e_g1, e_v0, e_v1;
    logic [AW-1:0] e_ma;
    logic [N-1:0]  e_d0, e_d1;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(string nm, logic r0, logic [AW-1:0] a0, logic l0,
                              logic r1, logic [AW-1:0] a1, logic l1,
                              logic g0, logic g1, logic v0, logic v1,
                              logic [AW-1:0] ma, logic [N-1:0] d0, logic [N-1:0] d1);
    vec_t v;
    v.name = nm; v.r0 = r0; v.a0 = a0; v.l0 = l0; v.r1 = r1; v.a1 = a1; v.l1 = l1;
    v.e_g0 = g0; v.e_g1 = g1; v.e_v0 = v0; v.e_v1 = v1; v.e_ma = ma; v.e_d0 = d0; v.e_d1 = d1;
    return v;
  endfunction

  task automatic check1(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic r0, logic [AW-1:0] a0, logic l0, logic r1, logic [AW-1:0] a1, logic l1);
    req0 = r0; addr0 = a0; lock0 = l0; req1 = r1; addr1 = a1; lock1 = l1;
  endtask

  initial begin
    // Outputs are sampled between the input change at negedge and the next posedge;
    // rvalid/rdata therefore reflect the previous row's grant.
    vecs[0]  = mk("rst_first",  1,0,0, 1,1,0,  1,0, 0,0, 0, 0,  0);
    vecs[1]  = mk("cont_1",     1,0,0, 1,1,0,  0,1, 1,0, 1, W0, 0);
    vecs[2]  = mk("cont_2",     1,0,0, 1,1,0,  1,0, 0,1, 0, W0, W1);
    vecs[3]  = mk("cont_3",     1,0,0, 1,1,0,  0,1, 1,0, 1, W0, W1);
    vecs[4]  = mk("idle_none",  0,2,0, 0,1,0,  0,0, 0,1, 2, W0, W1);
    vecs[5]  = mk("single0",    1,0,0, 0,1,0,  1,0, 0,0, 0, W0, W1);
    vecs[6]  = mk("idle_gap",   0,3,0, 0,1,0,  0,0, 1,0, 3, W0, W1);
    vecs[7]  = mk("lock1_a",    1,2,0, 1,1,1,  0,1, 0,0, 1, W0, W1);
    vecs[8]  = mk("lock1_b",    1,2,0, 1,3,1,  0,1, 0,1, 3, W0, W1);
    vecs[9]  = mk("lock1_c",    1,2,0, 1,2,1,  0,1, 0,1, 2, W0, W3);
    vecs[10] = mk("lock1_rel",  1,2,0, 1,0,0,  0,1, 0,1, 0, W0, W2);
    vecs[11] = mk("after_rel",  1,2,0, 1,1,0,  1,0, 0,1, 2, W0, W0);
    vecs[12] = mk("lock1_d",    1,0,0, 1,1,1,  0,1, 1,0, 1, W2, W0);
    vecs[13] = mk("lock1_drop", 1,0,0, 0,1,0,  0,0, 0,1, 0, W2, W1);
    vecs[14] = mk("drop_then0", 1,0,0, 0,1,0,  1,0, 0,0, 0, W2, W1);
    vecs[15] = mk("lock0_a",    1,1,1, 0,0,0,  1,0, 1,0, 1, W0, W1);
    vecs[16] = mk("lock0_hold", 1,4,0, 1,0,0,  1,0, 1,0, 4, W1, W1);
    vecs[17] = mk("oob_after",  0,0,0, 1,0,0,  0,1, 1,0, 0, 0,  W1);
    vecs[18] = mk("quiet",      0,0,0, 0,0,0,  0,0, 0,1, 0, 0,  W0);

    // Reset with both ports requesting: no grants, outputs cleared.
    reset = 1'b0;
    drive(1, 0, 0, 1, 1, 0);
    repeat (3) @(negedge clk);
    #2;
    check1("reset_outputs", {58'd0, gnt0, gnt1, rvalid0, rvalid1, 2'b00},
           {58'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
    check1("reset_rdata", {rdata0, rdata1}, 64'd0);

    // Table: row 0 is the first cycle after reset release.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (i == 0) reset = 1'b1;
      drive(vecs[i].r0, vecs[i].a0, vecs[i].l0, vecs[i].r1, vecs[i].a1, vecs[i].l1);
      #2;
      n_tests++;
      if ({gnt0, gnt1, rvalid0, rvalid1, mem_addr, rdata0, rdata1} !==
          {vecs[i].e_g0, vecs[i].e_g1, vecs[i].e_v0, vecs[i].e_v1, vecs[i].e_ma, vecs[i].e_d0, vecs[i].e_d1}) begin
        n_fail++;
        $display("FAIL %s: got g0=%b g1=%b v0=%b v1=%b ma=%0d d0=%h d1=%h, expected g0=%b g1=%b v0=%b v1=%b ma=%0d d0=%h d1=%h",
                 vecs[i].name, gnt0, gnt1, rvalid0, rvalid1, mem_addr, rdata0, rdata1,
                 vecs[i].e_g0, vecs[i].e_g1, vecs[i].e_v0, vecs[i].e_v1, vecs[i].e_ma, vecs[i].e_d0, vecs[i].e_d1);
      end
`ifdef IMEM_ARB_STATS_EN
      if (i == 4) begin
        check1("stats_gcnt0", {48'd0, gcnt0}, 64'd2);
        check1("stats_gcnt1", {48'd0, gcnt1}, 64'd2);
        check1("stats_ccnt",  {48'd0, ccnt},  64'd4);
      end
`endif
    end

    // Reset during a locked read: response dropped, lock released.
    @(negedge clk); drive(1, 0, 1, 0, 1, 0);
    #2; check1("mid_gnt_a", {63'd0, gnt0}, 64'd1);
    @(negedge clk); drive(1, 1, 1, 0, 1, 0);
    #2; check1("mid_gnt_b", {63'd0, gnt0}, 64'd1);
    #1 reset = 1'b0;
    #1; check1("mid_forced", {61'd0, gnt0, gnt1, rvalid0}, 64'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check1("mid_no_rvalid", {62'd0, rvalid0, rvalid1}, 64'd0);
    end
    check1("mid_rdata_clr", {32'd0, rdata0}, 64'd0);
    @(negedge clk); reset = 1'b1; drive(0, 0, 0, 1, 1, 0);
    #2; check1("mid_lock_rel", {62'd0, gnt0, gnt1}, 64'd1);

    // Reset returns last to port 1, so port 0 wins the next tie.
    @(negedge clk); drive(1, 0, 0, 0, 1, 0);
    #2; check1("pre_last0", {62'd0, gnt0, gnt1}, 64'd2);
    @(negedge clk); reset = 1'b0; drive(1, 0, 0, 1, 1, 0);
    @(negedge clk); reset = 1'b1;
    #2; check1("rst_last1", {62'd0, gnt0, gnt1}, 64'd2);

`ifdef IMEM_ARB_STATS_EN
    @(negedge clk); drive(0, 0, 0, 0, 1, 0);
    force dut.gcnt0_q = 16'hFFFF;
    #1 release dut.gcnt0_q;
    @(negedge clk); drive(1, 0, 0, 0, 1, 0);
    #2; check1("sat_gnt", {63'd0, gnt0}, 64'd1);
    @(negedge clk); drive(0, 0, 0, 0, 1, 0);
    #2; check1("sat_gcnt0", {48'd0, gcnt0}, 64'h0000_0000_0000_FFFF);
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
